lfsr_event_timer: RTL and testbench
===================================

Name: lfsr_event_timer

Overview:
- Downstream consumer of lfsr_updown: watches its count/overflow outputs and raises a timeout event after a programmed number of overflow epochs plus a programmed LFSR match state.
- Forms the programmable-timeout stage of the LFSR timer chain.
- Software or a control FSM arms it, waits for fire, then acknowledges.

Parameters:
- WIDTH, 8, LFSR state width; must equal the width of the upstream lfsr_updown count.
- EPOCH_W, 4, width of the overflow-epoch counter and threshold.

Ports:
- clk  input  1  rising-edge clock, shared with lfsr_updown.
- reset  input  1  synchronous, active-high reset.
- lfsr_count  input  WIDTH  count output of lfsr_updown.
- lfsr_overflow  input  1  overflow output of lfsr_updown.
- lfsr_enable  input  1  same enable that drives lfsr_updown; qualifies both lfsr inputs.
- arm  input  1  single-cycle request to start a timing run.
- match_in  input  WIDTH  target LFSR state, sampled on accepted arm.
- epochs_in  input  EPOCH_W  number of qualified overflows required before matching, sampled on accepted arm.
- ack  input  1  clears a pending fire.
- busy  output  1  high in ARMED.
- fire  output  1  high in FIRED; held until ack.
- miss  output  1  valid with fire: 1 = run ended on overflow without a match.
- epoch_cnt  output  EPOCH_W  qualified overflows seen in the current run.

Behaviour:
- States are IDLE, ARMED and FIRED, in a 2-bit encoding.
- Reset puts the block in IDLE with busy=0, fire=0, miss=0, epoch_cnt=0, and clears the match and epochs registers. Reset mid-run aborts the run with no fire.
- A qualified cycle is one with lfsr_enable=1. Cycles with lfsr_enable=0 are ignored entirely.
- IDLE:
  - arm=1 captures match_in and epochs_in, clears epoch_cnt and miss.
  - Next state is ARMED, so busy=1 on the following cycle.
- ARMED:
  - Comparisons use the registered epoch_cnt, i.e. the value before any increment in that cycle.
  - Hit: qualified cycle with epoch_cnt==epochs and lfsr_count==match. Next state is FIRED with miss=0. Latency: fire rises 1 cycle after the hit cycle.
  - Miss: qualified cycle with lfsr_overflow=1 and epoch_cnt==epochs and no hit. Next state is FIRED with miss=1. This guarantees termination when match is a state the LFSR never visits, e.g. the lock-up state.
  - Hit and overflow in the same cycle: hit wins, miss=0.
  - Otherwise, a qualified overflow increments epoch_cnt. epoch_cnt stays below or equal to epochs by construction, so no wrap is possible.
  - arm=1 in ARMED re-arms: new operands are captured, epoch_cnt is cleared, state stays ARMED. Re-arm has priority over hit and miss in that cycle.
  - ack in ARMED has no effect.
- FIRED:
  - fire=1 and miss stay stable. epoch_cnt is frozen.
  - ack=1 goes to IDLE on the next cycle: fire=0, and miss holds its value until the next arm.
  - arm in FIRED is ignored, including when it coincides with ack. Only arm in IDLE or ARMED is accepted.
- epochs=0 means a match is accepted in the first epoch; an overflow before the match ends the run with miss=1.
- Direction-agnostic: up_down changes upstream do not affect this block; only lfsr_count, lfsr_overflow and lfsr_enable are observed.

Decomposition:
- Shared header lfsr_defs.vh holds the WIDTH define used by lfsr_updown, plus the state-encoding constants S_IDLE=2'd0, S_ARMED=2'd1, S_FIRED=2'd2.
- No sub-module is required. The equality comparator and epoch counter are inline.

Test Plan:
- Reset held 3 cycles with arm=1 -> busy=0, fire=0, epoch_cnt=0 throughout and after release.
- Arm with match=8'h5A, epochs=0; drive lfsr_count=8'h5A with enable=1 four cycles later -> fire=1, miss=0 exactly 1 cycle after, busy=0.
- Arm with match=8'h33, epochs=2; pulse overflow 2 times (epoch_cnt 0->1->2), then present 8'h33 -> fire, miss=0. Also present 8'h33 while epoch_cnt=1 -> no fire.
- Arm with match=8'hFF, epochs=1; pulse overflow twice without 8'hFF -> fire with miss=1 after the second overflow, epoch_cnt=1.
- Present a hit with enable=0 -> no fire. Re-arm in ARMED with new match=8'h10 in the same cycle as an 8'h5A hit -> no fire, epoch_cnt=0, later fires on 8'h10.
- In FIRED assert ack and arm together -> IDLE next cycle, busy=0. Assert reset while ARMED -> IDLE, no fire.

Source files
------------

// File: rtl/lfsr_event_timer_pkg.sv
// rtl/lfsr_event_timer_pkg.sv - shared types and defaults for the LFSR event timer
// Holds the FSM state encoding (2-bit, matching the LFSR chain's shared
// S_IDLE/S_ARMED/S_FIRED constants) and the default widths of the timer.
package lfsr_event_timer_pkg;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_EPOCH_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FIRED = 2'd2
  } state_e;

endpackage

// File: rtl/lfsr_event_timer.sv
// rtl/lfsr_event_timer.sv - programmable timeout stage watching an lfsr_updown counter
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   lfsr_count      upstream LFSR state
//   lfsr_overflow   upstream overflow flag
//   lfsr_enable     upstream enable; qualifies count and overflow
//   arm             start (or restart) a run; captures match_in / epochs_in
//   match_in        target LFSR state
//   epochs_in       qualified overflows to wait before matching
//   ack             clears a pending fire
//   busy            run in progress
//   fire            run finished, held until ack
//   miss            with fire: run ended on overflow without a match
//   epoch_cnt       qualified overflows seen in the current run
module lfsr_event_timer
  import lfsr_event_timer_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int EPOCH_W = DEFAULT_EPOCH_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   lfsr_count,
  input  logic               lfsr_overflow,
  input  logic               lfsr_enable,
  input  logic               arm,
  input  logic [WIDTH-1:0]   match_in,
  input  logic [EPOCH_W-1:0] epochs_in,
  input  logic               ack,
  output logic               busy,
  output logic               fire,
  output logic               miss,
  output logic [EPOCH_W-1:0] epoch_cnt
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   match_q, match_d;
  logic [EPOCH_W-1:0] epochs_q, epochs_d;
  logic [EPOCH_W-1:0] epoch_cnt_q, epoch_cnt_d;
  logic               miss_q, miss_d;

  // Both tests use the registered epoch count, before any increment this cycle.
  logic last_epoch;
  logic hit;
  assign last_epoch = (epoch_cnt_q == epochs_q);
  assign hit        = last_epoch && (lfsr_count == match_q);

  always_comb begin
    state_d     = state_q;
    match_d     = match_q;
    epochs_d    = epochs_q;
    epoch_cnt_d = epoch_cnt_q;
    miss_d      = miss_q;

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          match_d     = match_in;
          epochs_d    = epochs_in;
          epoch_cnt_d = '0;
          miss_d      = 1'b0;
          state_d     = S_ARMED;
        end
      end

      S_ARMED: begin
        if (arm) begin
          // Re-arm outranks any hit or miss in the same cycle.
          match_d     = match_in;
          epochs_d    = epochs_in;
          epoch_cnt_d = '0;
          miss_d      = 1'b0;
        end else if (lfsr_enable) begin
          if (hit) begin
            miss_d  = 1'b0;
            state_d = S_FIRED;
          end else if (lfsr_overflow && last_epoch) begin
            // Ends runs whose target the LFSR never reaches (e.g. lock-up).
            miss_d  = 1'b1;
            state_d = S_FIRED;
          end else if (lfsr_overflow) begin
            // Only reachable while epoch_cnt < epochs, so it cannot wrap.
            epoch_cnt_d = epoch_cnt_q + EPOCH_W'(1);
          end
        end
      end

      S_FIRED: begin
        if (ack) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      match_q     <= '0;
      epochs_q    <= '0;
      epoch_cnt_q <= '0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_q     <= match_d;
      epochs_q    <= epochs_d;
      epoch_cnt_q <= epoch_cnt_d;
      miss_q      <= miss_d;
    end
  end

  assign busy      = (state_q == S_ARMED);
  assign fire      = (state_q == S_FIRED);
  assign miss      = miss_q;
  assign epoch_cnt = epoch_cnt_q;

endmodule

// File: tb/tb_lfsr_event_timer.sv
// tb/tb_lfsr_event_timer.sv - self-checking bench for lfsr_event_timer
module tb_lfsr_event_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] lfsr_count = 8'h00;
  logic       lfsr_overflow = 1'b0;
  logic       lfsr_enable = 1'b0;
  logic       arm = 1'b0;
  logic [7:0] match_in = 8'h00;
  logic [3:0] epochs_in = 4'h0;
  logic       ack = 1'b0;
  logic       busy, fire, miss;
  logic [3:0] epoch_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  lfsr_event_timer #(.WIDTH(8), .EPOCH_W(4)) dut (
    .clk(clk), .reset(reset),
    .lfsr_count(lfsr_count), .lfsr_overflow(lfsr_overflow), .lfsr_enable(lfsr_enable),
    .arm(arm), .match_in(match_in), .epochs_in(epochs_in), .ack(ack),
    .busy(busy), .fire(fire), .miss(miss), .epoch_cnt(epoch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: a run is "in progress" or "finished"; it tracks how many
  // qualified overflows have been seen and decides the outcome from the rules.
  bit         started = 0;
  bit         m_running = 0;
  bit         m_done = 0;
  bit         m_miss = 0;
  int         m_seen = 0;
  int         m_target_epochs = 0;
  int         m_target_state = 0;

  always @(posedge clk) begin
    started = 1;
    if (reset) begin
      m_running = 0; m_done = 0; m_miss = 0; m_seen = 0;
      m_target_epochs = 0; m_target_state = 0;
    end else if (arm && !m_done) begin
      m_running = 1; m_miss = 0; m_seen = 0;
      m_target_epochs = int'(epochs_in);
      m_target_state = int'(match_in);
    end else if (m_running && lfsr_enable) begin
      if (m_seen == m_target_epochs && int'(lfsr_count) == m_target_state) begin
        m_running = 0; m_done = 1; m_miss = 0;
      end else if (lfsr_overflow) begin
        if (m_seen == m_target_epochs) begin
          m_running = 0; m_done = 1; m_miss = 1;
        end else begin
          m_seen = m_seen + 1;
        end
      end
    end else if (m_done && ack) begin
      m_done = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("busy", {31'b0, busy}, {31'b0, m_running});
      check("fire", {31'b0, fire}, {31'b0, m_done});
      check("miss", {31'b0, miss}, {31'b0, m_miss});
      check("epoch_cnt", {28'b0, epoch_cnt}, 32'(m_seen));
    end
  end

  task automatic step(input logic a, input logic [7:0] m, input logic [3:0] e,
                      input logic k, input logic [7:0] c, input logic o, input logic en);
    arm = a; match_in = m; epochs_in = e; ack = k;
    lfsr_count = c; lfsr_overflow = o; lfsr_enable = en;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input logic [7:0] c, input logic o, input logic en);
    step(1'b0, 8'h00, 4'h0, 1'b0, c, o, en);
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    check({"lit_", name}, act, exp);
  endtask

  initial begin
    // Reset held with arm asserted
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hAA, 4'h3, 1'b0, 8'h00, 1'b0, 1'b1);
      lit("rst_busy", {31'b0, busy}, 0);
      lit("rst_fire", {31'b0, fire}, 0);
      lit("rst_cnt", {28'b0, epoch_cnt}, 0);
    end
    reset = 1'b0;
    idle(8'h00, 1'b0, 1'b1);
    lit("post_rst_busy", {31'b0, busy}, 0);
    lit("post_rst_fire", {31'b0, fire}, 0);

    // epochs=0 hit
    step(1'b1, 8'h5A, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1);
    lit("arm_busy", {31'b0, busy}, 1);
    for (int i = 0; i < 3; i++) idle(8'h01, 1'b0, 1'b1);
    lit("pre_hit_fire", {31'b0, fire}, 0);
    idle(8'h5A, 1'b0, 1'b1);
    lit("hit0_fire", {31'b0, fire}, 1);
    lit("hit0_miss", {31'b0, miss}, 0);
    lit("hit0_busy", {31'b0, busy}, 0);
    step(1'b0, 8'h00, 4'h0, 1'b1, 8'h00, 1'b0, 1'b1);
    lit("ack0_fire", {31'b0, fire}, 0);

    // epochs=2, early match ignored
    step(1'b1, 8'h33, 4'h2, 1'b0, 8'h00, 1'b0, 1'b1);
    idle(8'h01, 1'b1, 1'b1);
    lit("ep1_cnt", {28'b0, epoch_cnt}, 1);
    idle(8'h33, 1'b0, 1'b1);
    lit("early_fire", {31'b0, fire}, 0);
    lit("early_cnt", {28'b0, epoch_cnt}, 1);
    idle(8'h02, 1'b1, 1'b1);
    lit("ep2_cnt", {28'b0, epoch_cnt}, 2);
    idle(8'h33, 1'b0, 1'b1);
    lit("hit2_fire", {31'b0, fire}, 1);
    lit("hit2_miss", {31'b0, miss}, 0);
    lit("hit2_cnt", {28'b0, epoch_cnt}, 2);
    step(1'b0, 8'h00, 4'h0, 1'b1, 8'h00, 1'b0, 1'b1);

    // Miss after final epoch
    step(1'b1, 8'hFF, 4'h1, 1'b0, 8'h00, 1'b0, 1'b1);
    idle(8'h01, 1'b1, 1'b1);
    lit("m_cnt1", {28'b0, epoch_cnt}, 1);
    idle(8'h02, 1'b1, 1'b1);
    lit("miss_fire", {31'b0, fire}, 1);
    lit("miss_miss", {31'b0, miss}, 1);
    lit("miss_cnt", {28'b0, epoch_cnt}, 1);
    step(1'b0, 8'h00, 4'h0, 1'b1, 8'h00, 1'b0, 1'b1);
    lit("miss_ack_fire", {31'b0, fire}, 0);
    lit("miss_held", {31'b0, miss}, 1);

    // Disabled hit ignored; re-arm beats hit
    step(1'b1, 8'h5A, 4'h1, 1'b0, 8'h00, 1'b0, 1'b1);
    lit("rearm_prep_miss", {31'b0, miss}, 0);
    idle(8'h03, 1'b1, 1'b1);
    idle(8'h5A, 1'b0, 1'b0);
    lit("dis_fire", {31'b0, fire}, 0);
    lit("dis_busy", {31'b0, busy}, 1);
    step(1'b1, 8'h10, 4'h0, 1'b0, 8'h5A, 1'b0, 1'b1);
    lit("rearm_fire", {31'b0, fire}, 0);
    lit("rearm_busy", {31'b0, busy}, 1);
    lit("rearm_cnt", {28'b0, epoch_cnt}, 0);
    idle(8'h10, 1'b0, 1'b1);
    lit("rearm_hit", {31'b0, fire}, 1);

    // ack + arm in FIRED
    step(1'b1, 8'h77, 4'h0, 1'b1, 8'h00, 1'b0, 1'b1);
    lit("ackarm_busy", {31'b0, busy}, 0);
    lit("ackarm_fire", {31'b0, fire}, 0);
    idle(8'h77, 1'b0, 1'b1);
    lit("ackarm_idle", {31'b0, busy}, 0);

    // Hit and overflow together: hit wins
    step(1'b1, 8'h20, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1);
    idle(8'h20, 1'b1, 1'b1);
    lit("both_fire", {31'b0, fire}, 1);
    lit("both_miss", {31'b0, miss}, 0);
    step(1'b0, 8'h00, 4'h0, 1'b1, 8'h00, 1'b0, 1'b1);

    // Lock-up target with epochs=0: first overflow misses
    step(1'b1, 8'h00, 4'h0, 1'b0, 8'h05, 1'b0, 1'b1);
    idle(8'h01, 1'b1, 1'b1);
    lit("lock_fire", {31'b0, fire}, 1);
    lit("lock_miss", {31'b0, miss}, 1);
    step(1'b0, 8'h00, 4'h0, 1'b1, 8'h00, 1'b0, 1'b1);

    // ack in ARMED ignored; reset aborts the run
    step(1'b1, 8'h44, 4'h3, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 4'h0, 1'b1, 8'h01, 1'b0, 1'b1);
    lit("ack_armed_busy", {31'b0, busy}, 1);
    reset = 1'b1;
    idle(8'h01, 1'b0, 1'b1);
    lit("abort_busy", {31'b0, busy}, 0);
    lit("abort_fire", {31'b0, fire}, 0);
    lit("abort_cnt", {28'b0, epoch_cnt}, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(8'h44, 1'b1, 1'b1);
      lit("abort_nofire", {31'b0, fire}, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
